alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_ctl_decode.sv | 37 +++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: ALU control bits,
// named control words, op codes and sequencer states.
package alu_pkg;

    localparam logic [5:0] EX = 6'd32;
    localparam logic [5:0] NX = 6'd16;
    localparam logic [5:0] EY = 6'd8;
    localparam logic [5:0] NY = 6'd4;
    localparam logic [5:0] F  = 6'd2;
    localparam logic [5:0] NO = 6'd1;

    // x+y, x-y = ~(~x+y), x|y = ~(~x & ~y), x+1 = ~(~x + -1), x-1 = x + -1
    localparam logic [5:0] ALU_ADD   = EX | EY | F;
    localparam logic [5:0] ALU_SUB   = EX | EY | NX | F | NO;
    localparam logic [5:0] ALU_AND   = EX | EY;
    localparam logic [5:0] ALU_OR    = EX | EY | NX | NY | NO;
    localparam logic [5:0] ALU_INC   = NX | EX | NY | F | NO;
    localparam logic [5:0] ALU_DEC   = EX | NY | F;
    localparam logic [5:0] ALU_PASSX = EX | F;
    localparam logic [5:0] ALU_ZERO  = F;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_INC = 3'd4,
        OP_DEC = 3'd5,
        OP_SHL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake between the microcode controller (master)
// and the ALU operation sequencer (slave).
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 4
);
    logic          start;
    op_e           op;
    logic [W-1:0]  x_in;
    logic [W-1:0]  y_in;
    logic [CW-1:0] count;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    modport master (
        output start, op, x_in, y_in, count,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, op, x_in, y_in, count,
        output ready, busy, done, result
    );
endinterface

// File: rtl/alu_ctl_decode.sv
// Maps an op code to the ALU control word, the Y-operand source and
// whether the op iterates with accumulator feedback.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  op_e        op,
    output logic [5:0] alu_c,
    output logic       select_y_acc,
    output logic       iterative
);

    // op-code decode table
    always_comb begin
        alu_c        = ALU_ZERO;
        select_y_acc = 1'b0;
        iterative    = 1'b0;
        case (op)
            OP_ADD:  alu_c = ALU_ADD;
            OP_SUB:  alu_c = ALU_SUB;
            OP_AND:  alu_c = ALU_AND;
            OP_OR:   alu_c = ALU_OR;
            OP_INC:  alu_c = ALU_INC;
            OP_DEC:  alu_c = ALU_DEC;
            OP_SHL: begin
                alu_c        = ALU_ADD;
                select_y_acc = 1'b1;
                iterative    = 1'b1;
            end
            OP_MUL: begin
                alu_c     = ALU_ADD;
                iterative = 1'b1;
            end
            default: alu_c = ALU_ZERO;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the ALU control interface for one requested operation, iterating
// with accumulator feedback for shift-left and repeated-add.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int W  = 16,
    parameter int CW = 4
)
(
    input  logic             clk,
    input  logic             reset_n,
    alu_op_sequencer_if.slave bus,
    output logic [W-1:0]     alu_x,
    output logic [W-1:0]     alu_y,
    output logic [5:0]       alu_c,
    output logic             alu_en,
    input  logic [W-1:0]     alu_out
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e        state_r, state_s;
    op_e           op_r, op_s;
    logic [W-1:0]  acc_r, acc_s;
    logic [W-1:0]  y_r, y_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          iter_r;

    logic [5:0]    dec_c_s;
    logic          sel_y_acc_s;
    logic          iter_s;

    logic [W-1:0]  alu_x_s, alu_y_s;
    logic [5:0]    alu_c_s;

    logic          ready_r, busy_r, done_r, alu_en_r;
    logic [W-1:0]  alu_x_r, alu_y_r;
    logic [5:0]    alu_c_r;

    alu_ctl_decode u_decode (
        .op           (op_s),
        .alu_c        (dec_c_s),
        .select_y_acc (sel_y_acc_s),
        .iterative    (iter_s)
    );

    // next-state, operand latching and accumulator feedback
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        acc_s   = acc_r;
        y_s     = y_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    op_s    = bus.op;
                    y_s     = bus.y_in;
                    cnt_s   = bus.count;
                    acc_s   = (bus.op == OP_MUL) ? {W{1'b0}} : bus.x_in;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                acc_s = alu_out;
                if (iter_r && (cnt_r > CNT_ONE)) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_DONE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // ALU drive for the upcoming cycle; a zero-count iterative op just passes X
    always_comb begin
        alu_x_s = {W{1'b0}};
        alu_y_s = {W{1'b0}};
        alu_c_s = 6'd0;
        if (state_s == ST_EXEC) begin
            alu_x_s = acc_s;
            alu_y_s = sel_y_acc_s ? acc_s : y_s;
            alu_c_s = (iter_s && (cnt_s == CNT_ZERO)) ? ALU_PASSX : dec_c_s;
        end else begin
            alu_c_s = 6'd0;
        end
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_ADD;
            acc_r    <= {W{1'b0}};
            y_r      <= {W{1'b0}};
            cnt_r    <= CNT_ZERO;
            iter_r   <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            alu_en_r <= 1'b0;
            alu_x_r  <= {W{1'b0}};
            alu_y_r  <= {W{1'b0}};
            alu_c_r  <= 6'd0;
        end else begin
            state_r  <= state_s;
            op_r     <= op_s;
            acc_r    <= acc_s;
            y_r      <= y_s;
            cnt_r    <= cnt_s;
            iter_r   <= iter_s;
            ready_r  <= (state_s == ST_IDLE);
            busy_r   <= (state_s == ST_EXEC);
            done_r   <= (state_s == ST_DONE);
            alu_en_r <= (state_s == ST_EXEC);
            alu_x_r  <= alu_x_s;
            alu_y_r  <= alu_y_s;
            alu_c_r  <= alu_c_s;
        end
    end

    assign bus.ready  = ready_r;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = acc_r;
    assign alu_x      = alu_x_r;
    assign alu_y      = alu_y_r;
    assign alu_c      = alu_c_r;
    assign alu_en     = alu_en_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised and directed bench for alu_op_sequencer with an ALU model and
// an arithmetic reference for results, latency and control words.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  alu_x, alu_y, alu_out;
    logic [5:0]    alu_c;
    logic          alu_en;
    logic [W-1:0]  ax_s, ay_s, ao_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.W(W), .CW(CW)) bus ();

    alu_op_sequencer #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .alu_x   (alu_x),
        .alu_y   (alu_y),
        .alu_c   (alu_c),
        .alu_en  (alu_en),
        .alu_out (alu_out)
    );

    // ALU: {ex,nx,ey,ny,f,no}
    always_comb begin
        ax_s = alu_c[5] ? alu_x : 16'd0;
        if (alu_c[4]) ax_s = ~ax_s;
        ay_s = alu_c[3] ? alu_y : 16'd0;
        if (alu_c[2]) ay_s = ~ay_s;
        ao_s = alu_c[1] ? (ax_s + ay_s) : (ax_s & ay_s);
        if (alu_c[0]) ao_s = ~ao_s;
        alu_out = ao_s;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_result(input int o, input logic [15:0] x,
                                                 input logic [15:0] y, input int c);
        case (o)
            0: return x + y;
            1: return x - y;
            2: return x & y;
            3: return x | y;
            4: return x + 16'd1;
            5: return x - 16'd1;
            6: return x << c;
            7: return 16'(int'(y) * c);
            default: return 16'd0;
        endcase
    endfunction

    function automatic int model_cycles(input int o, input int c);
        return (o >= 6 && c > 1) ? c : 1;
    endfunction

    function automatic int model_ctl(input int o, input int c);
        case (o)
            0: return 42;
            1: return 59;
            2: return 40;
            3: return 61;
            4: return 55;
            5: return 38;
            default: return (c == 0) ? 34 : 42;
        endcase
    endfunction

    task automatic run_op(input int o, input logic [15:0] x, input logic [15:0] y,
                          input int c, input bit poke, input string name);
        int execs, dones, done_idx, ready_idx, first_c, bad_drive, n;
        logic [15:0] er, res_done;
        er        = model_result(o, x, y, c);
        n         = model_cycles(o, c);
        execs     = 0;
        dones     = 0;
        done_idx  = 0;
        ready_idx = 0;
        first_c   = -1;
        bad_drive = 0;
        res_done  = 16'd0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_e'(o);
        bus.x_in  = x;
        bus.y_in  = y;
        bus.count = CW'(c);
        @(negedge clk);
        if (poke) begin
            bus.op    = OP_ADD;
            bus.x_in  = 16'h1234;
            bus.y_in  = 16'h1111;
            bus.count = 4'd9;
        end else begin
            bus.start = 1'b0;
        end
        for (int i = 1; i <= 64; i++) begin
            if (bus.busy) begin
                execs++;
                if (first_c < 0) first_c = int'(alu_c);
                if (!alu_en) bad_drive++;
            end else if (alu_en || alu_c != 6'd0) begin
                bad_drive++;
            end
            if (bus.done) begin
                dones++;
                done_idx = i;
                res_done = bus.result;
            end
            if (bus.ready) begin
                ready_idx = i;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (ready_idx == 0) chk({name, " timeout"}, 32'd0, 32'd1);
        chk({name, " exec_cycles"}, execs, n);
        chk({name, " done_count"}, dones, 32'd1);
        chk({name, " done_cycle"}, done_idx, n + 1);
        chk({name, " ready_cycle"}, ready_idx, n + 2);
        chk({name, " result"}, res_done, er);
        chk({name, " result_hold"}, bus.result, er);
        chk({name, " alu_c"}, first_c, model_ctl(o, c));
        chk({name, " bus_drive"}, bad_drive, 32'd0);
    endtask

    initial begin
        int dn;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_ADD;
        bus.x_in  = 16'd0;
        bus.y_in  = 16'd0;
        bus.count = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst ready", bus.ready, 32'd1);
        chk("rst busy", bus.busy, 32'd0);
        chk("rst done", bus.done, 32'd0);
        chk("rst result", bus.result, 32'd0);
        chk("rst alu_c", alu_c, 32'd0);
        chk("rst alu_en", alu_en, 32'd0);
        chk("rst alu_x", alu_x, 32'd0);
        chk("rst alu_y", alu_y, 32'd0);
        reset_n = 1'b1;

        run_op(0, 16'd1020, 16'd1567, 0, 1'b0, "add");
        run_op(1, 16'd1020, 16'd1567, 0, 1'b0, "sub");
        run_op(2, 16'hF0F0, 16'h3C3C, 0, 1'b0, "and");
        run_op(3, 16'hF0F0, 16'h3C3C, 0, 1'b0, "or");
        run_op(6, 16'd3, 16'd0, 4, 1'b0, "shl4");
        run_op(6, 16'h8001, 16'd0, 1, 1'b0, "shl_ovf");
        run_op(6, 16'h1357, 16'd0, 0, 1'b0, "shl0");
        run_op(7, 16'd999, 16'd1567, 3, 1'b0, "mul3");
        run_op(7, 16'd999, 16'd1567, 0, 1'b0, "mul0");
        run_op(4, 16'hFFFF, 16'd0, 0, 1'b0, "inc_wrap");
        run_op(5, 16'h0000, 16'd0, 0, 1'b0, "dec_wrap");
        run_op(6, 16'd5, 16'd0, 3, 1'b1, "shl_poke");
        run_op(1, 16'd7, 16'd9, 0, 1'b1, "sub_poke");

        // reset during the second EXEC cycle of a long shift
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_SHL;
        bus.x_in  = 16'd3;
        bus.count = 4'd8;
        @(negedge clk);
        bus.start = 1'b0;
        chk("abort exec1 busy", bus.busy, 32'd1);
        @(negedge clk);
        chk("abort exec2 busy", bus.busy, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort ready", bus.ready, 32'd1);
        chk("abort result", bus.result, 32'd0);
        chk("abort alu_en", alu_en, 32'd0);
        chk("abort busy", bus.busy, 32'd0);
        chk("abort alu_c", alu_c, 32'd0);
        reset_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("abort no_done", dn, 32'd0);
        run_op(0, 16'd1020, 16'd1567, 0, 1'b0, "add_after_abort");

        for (int t = 0; t < 40; t++) begin
            run_op(int'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
